dtw_ref_sched: RTL and testbench
================================

// Module: dtw_ref_sched
// PURPOSE
//  Sequencer and read-port arbiter for the shared dtw_core_ref reference memory. Drives the core's
//  rs/op_mode/ref_len controls to run a reference load, then switches it to DTW_READ mode and shares
//  its single read port among NUM_REQ DTW lanes. Arbitration is round-robin, one grant per cycle.
//  Read data returns on a broadcast bus, tagged by a per-lane valid strobe.
// PARAMETERS
//  NUM_REQ          4   number of DTW lane requesters (>=2)
//  DATA_WIDTH       16  reference sample width
//  ADDR_WIDTH       32  ref_len config width
//  REFMEM_PTR_WIDTH 20  reference memory address width
//  READ_LAT         2   cycles from ref_addr_out to valid ref_data_in (1 addr reg + 1 mem reg)
// PORTS
//  clk_in            in   1                    clock
//  rst_n_in          in   1                    reset, asynchronous, active-low
//  load_start_in     in   1                    1-cycle pulse: (re)load reference of ref_len_in samples
//  ref_len_in        in   ADDR_WIDTH           reference length, sampled on accepted load_start_in
//  ready_out         out  1                    reference loaded and arbiter serving
//  state_out         out  3                    FSM state (debug)
//  core_rs_out       out  1                    to dtw_core_ref rs_in
//  core_op_mode_out  out  1                    to op_mode_in; 0=DTW_READ, 1=LOAD_REF
//  core_ref_len_out  out  ADDR_WIDTH           to ref_len_in (registered copy)
//  core_addr_out     out  REFMEM_PTR_WIDTH     to ref_addr_in
//  core_busy_in      in   1                    from busy_out
//  core_load_done_in in   1                    from ref_load_done_out
//  core_data_in      in   DATA_WIDTH           from ref_data_out
//  req_in            in   NUM_REQ              per-lane read request; level, held until granted
//  addr_in           in   NUM_REQ*PTR          per-lane address; lane i at [i*PTR +: PTR]
//  gnt_out           out  NUM_REQ              one-hot grant; lane may drop/change req next cycle
//  rvalid_out        out  NUM_REQ              one-hot; data for lane i valid on rdata_out
//  rdata_out         out  DATA_WIDTH           broadcast read data
// BEHAVIOUR
//  Reset (async): state=IDLE. All outputs 0: core_rs, op_mode=0, core_addr, gnt, rvalid, rdata,
//   ready, core_ref_len. rr pointer=0. In-flight pipe cleared. Reset mid-load/mid-read aborts silently.
//  FSM (all outputs registered):
//   IDLE: rs=0, op_mode=1. load_start_in -> latch ref_len_in, go LOAD.
//   LOAD: rs=1, op_mode=1. Wait for core_load_done_in=1, then go ENTER (rs=0 for one cycle).
//   ENTER: op_mode=0, rs=1. Wait core_busy_in=1 (core in DTW_READ), then go SERVE, ready_out=1.
//   SERVE: arbitrate. load_start_in -> latch len, ready=0, gnt stops same cycle, go DRAIN.
//   DRAIN: no grants for READ_LAT cycles; in-flight rvalids still complete. Then op_mode=1, go LOAD.
//  load_start_in outside IDLE/SERVE: ignored. ref_len_in==0: LOAD exits when the core returns idle
//   (core_busy_in=0 for 2 cycles); ready_out=1 with empty ref.
//  Arbitration (SERVE only): lanes scanned from rr_ptr upward, wrapping at NUM_REQ-1 -> 0.
//   First lane with req set is granted. gnt_out, core_addr_out <= that lane's addr.
//   rr_ptr <= granted+1 (mod NUM_REQ). No req: gnt=0, core_addr holds, rr_ptr holds.
//  Latency: grant at cycle t. rvalid_out[i]=1 and rdata_out=mem[addr] at cycle t+READ_LAT.
//   Throughput is 1 read/cycle.
//  Pipe: READ_LAT-deep shift register of {valid, lane id}. rdata_out <= core_data_in when pipe
//   tail valid, else holds.
//  Width: core_addr is truncated to REFMEM_PTR_WIDTH. rr_ptr is $clog2(NUM_REQ) bits with
//   explicit wrap for non-power-of-2 NUM_REQ.
//  Simultaneous: load_start_in with active reqs in SERVE -> no grant that cycle; load wins.
// STRUCTURE
//  Package dtw_sched_pkg: FSM state localparams (IDLE=0, LOAD=1, ENTER=2, SERVE=3, DRAIN=4),
//   MODE_DTW_READ/MODE_LOAD_REF constants.
//  Sub-module dtw_rr_arbiter (req, rr_ptr -> one-hot gnt, gnt index); the pipe stays inline.
// TESTING (bench instantiates dtw_core_ref + FIFO model)
//  1. Load 8 samples 0x10..0x17, len=8 -> LOAD to ENTER to SERVE, ready_out=1. Lane0 reads addr 3
//     -> rvalid_out=0001, rdata=0x13 exactly 2 cycles after grant.
//  2. All 4 reqs held, distinct addrs -> gnt order 0,1,2,3,0 on consecutive cycles. Each rvalid
//     matches its lane's data.
//  3. Only lane2 requests, after rr_ptr=3 -> grant lane2 (wrap). rr_ptr=3 next.
//  4. load_start_in while 2 reads in flight -> both rvalids arrive, no new gnt, ready=0.
//     Reload 4 samples, ready=1. New data is read back correctly.
//  5. rst_n_in low mid-SERVE with in-flight read -> all outputs 0 immediately, no rvalid after release.
//  6. NUM_REQ=3 build: 3 lanes continuous -> grants 0,1,2,0. Never index 3.

Source files
------------

// File: rtl/dtw_sched_pkg.sv
// Shared types and constants for the reference-memory scheduler.
package dtw_sched_pkg;

  // Numeric encodings are visible on state_out for debug.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StEnter = 3'd2,
    StServe = 3'd3,
    StDrain = 3'd4
  } sched_state_e;

  // op_mode encodings understood by dtw_core_ref.
  localparam logic ModeDtwRead = 1'b0;
  localparam logic ModeLoadRef = 1'b1;

endpackage

// File: rtl/dtw_ref_sched_if.sv
// Lane-side read bus: per-lane requests/addresses in, one-hot grant/valid and broadcast data out.
interface dtw_ref_sched_if #(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned REFMEM_PTR_WIDTH = 20
) ();

  logic [NUM_REQ-1:0]                  req;
  logic [NUM_REQ*REFMEM_PTR_WIDTH-1:0] addr;
  logic [NUM_REQ-1:0]                  gnt;
  logic [NUM_REQ-1:0]                  rvalid;
  logic [DATA_WIDTH-1:0]               rdata;

  // Lanes drive requests and consume data.
  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  // The scheduler arbitrates and returns data.
  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/dtw_rr_arbiter.sv
// Combinational round-robin pick: first requesting lane at or after ptr_i, wrapping at NUM_REQ.
module dtw_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PtrW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PtrW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PtrW-1:0]    idx_o,
  output logic               valid_o
);

  // Scan lanes ptr_i, ptr_i+1, ... with an explicit wrap so non-power-of-2 counts never overflow.
  always_comb begin
    logic [PtrW:0]   sum;
    logic [PtrW-1:0] lane;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    lane    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_i} + (PtrW + 1)'(i);
      if (sum >= (PtrW + 1)'(NUM_REQ)) begin
        sum = sum - (PtrW + 1)'(NUM_REQ);
      end
      lane = sum[PtrW-1:0];
      if (!valid_o && req_i[lane]) begin
        valid_o     = 1'b1;
        idx_o       = lane;
        gnt_o[lane] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dtw_ref_sched.sv
// Sequences dtw_core_ref through a reference load, then shares its read port among NUM_REQ lanes.
module dtw_ref_sched
  import dtw_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned REFMEM_PTR_WIDTH = 20,
  parameter int unsigned READ_LAT         = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        load_start_in,
  input  logic [ADDR_WIDTH-1:0]       ref_len_in,
  output logic                        ready_out,
  output logic [2:0]                  state_out,
  output logic                        core_rs_out,
  output logic                        core_op_mode_out,
  output logic [ADDR_WIDTH-1:0]       core_ref_len_out,
  output logic [REFMEM_PTR_WIDTH-1:0] core_addr_out,
  input  logic                        core_busy_in,
  input  logic                        core_load_done_in,
  input  logic [DATA_WIDTH-1:0]       core_data_in,
  dtw_ref_sched_if.slave              lane_if
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  // Shared by the drain timer and the empty-reference idle counter.
  localparam int unsigned CntW = $clog2(READ_LAT + 2);

  sched_state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0]       len_q, len_d;
  logic                        rs_q, rs_d;
  logic                        mode_q, mode_d;
  logic                        ready_q, ready_d;
  logic [REFMEM_PTR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_REQ-1:0]          gnt_q, gnt_d;
  logic [NUM_REQ-1:0]          rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
  logic [PtrW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic                        pipe_vld_q [READ_LAT];
  logic                        pipe_vld_d [READ_LAT];
  logic [PtrW-1:0]             pipe_id_q  [READ_LAT];
  logic [PtrW-1:0]             pipe_id_d  [READ_LAT];

  logic [NUM_REQ-1:0]          arb_gnt;
  logic [PtrW-1:0]             arb_idx;
  logic                        arb_valid;
  logic                        issue;

  dtw_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (lane_if.req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Next-state and registered-output logic for the load/serve sequencer.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rs_d     = rs_q;
    mode_d   = mode_q;
    ready_d  = ready_q;
    addr_d   = addr_q;
    gnt_d    = '0;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    issue    = 1'b0;
    unique case (state_q)
      StIdle: begin
        rs_d   = 1'b0;
        mode_d = ModeLoadRef;
        if (load_start_in) begin
          len_d   = ref_len_in;
          rs_d    = 1'b1;
          cnt_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        rs_d   = 1'b1;
        mode_d = ModeLoadRef;
        if (len_q == '0) begin
          // Nothing to load: the core never pulses done, so wait for it to sit idle.
          if (core_busy_in) begin
            cnt_d = '0;
          end else if (cnt_q == CntW'(1)) begin
            rs_d    = 1'b0;
            mode_d  = ModeDtwRead;
            state_d = StEnter;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (core_load_done_in) begin
          // One rs-low cycle lets the core return to idle before the mode switch.
          rs_d    = 1'b0;
          mode_d  = ModeDtwRead;
          state_d = StEnter;
        end
      end
      StEnter: begin
        rs_d   = 1'b1;
        mode_d = ModeDtwRead;
        if (core_busy_in) begin
          ready_d = 1'b1;
          state_d = StServe;
        end
      end
      StServe: begin
        if (load_start_in) begin
          len_d   = ref_len_in;
          ready_d = 1'b0;
          cnt_d   = '0;
          state_d = StDrain;
        end else if (arb_valid) begin
          gnt_d  = arb_gnt;
          addr_d = lane_if.addr[int'(arb_idx) * REFMEM_PTR_WIDTH +: REFMEM_PTR_WIDTH];
          issue  = 1'b1;
          if (arb_idx == PtrW'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = arb_idx + 1'b1;
          end
        end
      end
      StDrain: begin
        // Core stays in read mode until the last granted read has produced its data.
        if (cnt_q == CntW'(READ_LAT - 1)) begin
          cnt_d   = '0;
          mode_d  = ModeLoadRef;
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Read-return pipe: tags each grant with its lane so data can be steered READ_LAT cycles later.
  always_comb begin
    pipe_vld_d[0] = issue;
    pipe_id_d[0]  = arb_idx;
    for (int i = 1; i < int'(READ_LAT); i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (pipe_vld_q[READ_LAT-1]) begin
      rvalid_d[pipe_id_q[READ_LAT-1]] = 1'b1;
      rdata_d                         = core_data_in;
    end
  end

  // State and output registers; reset aborts any load or in-flight read.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= StIdle;
      len_q    <= '0;
      rs_q     <= 1'b0;
      mode_q   <= ModeDtwRead;
      ready_q  <= 1'b0;
      addr_q   <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(READ_LAT); i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_id_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rs_q     <= rs_d;
      mode_q   <= mode_d;
      ready_q  <= ready_d;
      addr_q   <= addr_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < int'(READ_LAT); i++) begin
        pipe_vld_q[i] <= pipe_vld_d[i];
        pipe_id_q[i]  <= pipe_id_d[i];
      end
    end
  end

  assign ready_out        = ready_q;
  assign state_out        = state_q;
  assign core_rs_out      = rs_q;
  assign core_op_mode_out = mode_q;
  assign core_ref_len_out = len_q;
  assign core_addr_out    = addr_q;
  assign lane_if.gnt      = gnt_q;
  assign lane_if.rvalid   = rvalid_q;
  assign lane_if.rdata    = rdata_q;

endmodule

// File: tb/tb_dtw_ref_sched.sv
// Directed bench: 4-lane scheduler against a behavioural core + sample FIFO, plus a 3-lane build.
module tb_dtw_ref_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // 4-lane DUT and behavioural dtw_core_ref
  logic        load_start;
  logic [31:0] ref_len;
  logic        ready;
  logic [2:0]  state;
  logic        core_rs, core_mode;
  logic [31:0] core_len;
  logic [19:0] core_addr;
  logic        core_busy, core_done;
  logic [15:0] core_data;

  dtw_ref_sched_if #(.NUM_REQ(4), .DATA_WIDTH(16), .REFMEM_PTR_WIDTH(20)) lif4 ();

  dtw_ref_sched #(.NUM_REQ(4)) dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .load_start_in     (load_start),
    .ref_len_in        (ref_len),
    .ready_out         (ready),
    .state_out         (state),
    .core_rs_out       (core_rs),
    .core_op_mode_out  (core_mode),
    .core_ref_len_out  (core_len),
    .core_addr_out     (core_addr),
    .core_busy_in      (core_busy),
    .core_load_done_in (core_done),
    .core_data_in      (core_data),
    .lane_if           (lif4)
  );

  logic [15:0] mem [256];
  logic [15:0] fifo [$];
  int          c_st;   // 0 idle, 1 loading, 2 load done, 3 read mode
  int          c_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_st      <= 0;
      c_cnt     <= 0;
      core_data <= '0;
    end else begin
      core_data <= mem[core_addr[7:0]];
      case (c_st)
        0: begin
          if (core_rs && core_mode && core_len != 0) begin
            c_st  <= 1;
            c_cnt <= 0;
          end else if (core_rs && !core_mode) begin
            c_st <= 3;
          end
        end
        1: begin
          if (fifo.size() > 0) mem[c_cnt] <= fifo.pop_front();
          c_cnt <= c_cnt + 1;
          if (c_cnt + 1 == int'(core_len)) c_st <= 2;
        end
        2: if (!core_rs) c_st <= 0;
        3: if (!core_rs || core_mode) c_st <= 0;
        default: c_st <= 0;
      endcase
    end
  end
  assign core_busy = (c_st == 1) || (c_st == 3);
  assign core_done = (c_st == 2);

  // 3-lane DUT with a trivially driven core: data = address + 0x100
  logic        load_start3;
  logic [31:0] ref_len3;
  logic        ready3;
  logic [2:0]  state3;
  logic        core3_rs, core3_mode;
  logic [31:0] core3_len;
  logic [19:0] core3_addr;
  logic        core3_busy, core3_done;
  logic [15:0] core3_data;

  dtw_ref_sched_if #(.NUM_REQ(3), .DATA_WIDTH(16), .REFMEM_PTR_WIDTH(20)) lif3 ();

  dtw_ref_sched #(.NUM_REQ(3)) dut3 (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .load_start_in     (load_start3),
    .ref_len_in        (ref_len3),
    .ready_out         (ready3),
    .state_out         (state3),
    .core_rs_out       (core3_rs),
    .core_op_mode_out  (core3_mode),
    .core_ref_len_out  (core3_len),
    .core_addr_out     (core3_addr),
    .core_busy_in      (core3_busy),
    .core_load_done_in (core3_done),
    .core_data_in      (core3_data),
    .lane_if           (lif3)
  );

  always @(posedge clk) core3_data <= core3_addr[15:0] + 16'h0100;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int bound, input string tag, output logic saw_enter);
    saw_enter = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (ready) break;
      if (state == 3'd2) saw_enter = 1'b1;
      tick();
    end
    chk(tag, ready, 1);
  endtask

  // Single-lane read: grant next cycle, data exactly two cycles after the grant.
  task automatic read1(input int lane, input logic [19:0] a, input logic [15:0] d,
                       input string tag);
    logic [3:0] r;
    r       = '0;
    r[lane] = 1'b1;
    lif4.addr[lane*20 +: 20] = a;
    lif4.req = r;
    tick();
    chk({tag, " gnt"}, lif4.gnt, r);
    chk({tag, " addr"}, core_addr, a);
    lif4.req = '0;
    tick();
    chk({tag, " early rvalid"}, lif4.rvalid, 0);
    tick();
    chk({tag, " rvalid"}, lif4.rvalid, r);
    chk({tag, " rdata"}, lif4.rdata, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]  exp_g [5];
    logic [15:0] exp_d [5];
    logic [2:0]  exp_g3 [4];
    logic [15:0] exp_d3 [4];
    logic        saw;
    n_vec = 0;
    n_err = 0;
    load_start  = 1'b0;
    ref_len     = '0;
    lif4.req    = '0;
    lif4.addr   = '0;
    load_start3 = 1'b0;
    ref_len3    = '0;
    lif3.req    = '0;
    lif3.addr   = '0;
    core3_busy  = 1'b0;
    core3_done  = 1'b0;

    // Reset state
    #12;
    chk("rst state", state, 0);
    chk("rst ready", ready, 0);
    chk("rst rs", core_rs, 0);
    chk("rst mode", core_mode, 0);
    chk("rst len", core_len, 0);
    chk("rst addr", core_addr, 0);
    chk("rst gnt", lif4.gnt, 0);
    chk("rst rvalid", lif4.rvalid, 0);
    chk("rst rdata", lif4.rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle mode", core_mode, 1);

    // 1: load 8 samples, then a single lane0 read
    for (int i = 0; i < 8; i++) fifo.push_back(16'h0010 + 16'(i));
    load_start = 1'b1;
    ref_len    = 32'd8;
    tick();
    load_start = 1'b0;
    chk("t1 state load", state, 1);
    chk("t1 len latched", core_len, 8);
    wait_ready(60, "t1 ready", saw);
    chk("t1 enter seen", saw, 1);
    chk("t1 state serve", state, 3);
    chk("t1 mode read", core_mode, 0);
    read1(0, 20'd3, 16'h0013, "t1 lane0");
    // Lane3 alone from ptr=1 brings the pointer back to 0
    read1(3, 20'd7, 16'h0017, "t1 lane3");

    // 2: all lanes held -> 0,1,2,3,0
    lif4.addr = {20'd1, 20'd6, 20'd5, 20'd4};
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d = '{16'h0014, 16'h0015, 16'h0016, 16'h0011, 16'h0014};
    lif4.req = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k < 5) chk($sformatf("t2 gnt %0d", k), lif4.gnt, exp_g[k]);
      else chk($sformatf("t2 gnt idle %0d", k), lif4.gnt, 0);
      if (k >= 2) begin
        chk($sformatf("t2 rvalid %0d", k), lif4.rvalid, exp_g[k-2]);
        chk($sformatf("t2 rdata %0d", k), lif4.rdata, exp_d[k-2]);
      end
      if (k == 4) lif4.req = '0;
    end

    // 3: ptr=1 -> lane2 (ptr->3), lane2 again wraps from 3, then lanes 0+3 resolve 3 first
    read1(2, 20'd2, 16'h0012, "t3 lane2");
    read1(2, 20'd0, 16'h0010, "t3 lane2 wrap");
    lif4.addr[0 +: 20]  = 20'd5;
    lif4.addr[60 +: 20] = 20'd6;
    lif4.req = 4'b1001;
    tick();
    chk("t3 gnt lane3", lif4.gnt, 4'b1000);
    lif4.req = 4'b0001;
    tick();
    chk("t3 gnt lane0", lif4.gnt, 4'b0001);
    lif4.req = '0;
    tick();
    chk("t3 rvalid lane3", lif4.rvalid, 4'b1000);
    chk("t3 rdata lane3", lif4.rdata, 16'h0016);
    tick();
    chk("t3 rvalid lane0", lif4.rvalid, 4'b0001);
    chk("t3 rdata lane0", lif4.rdata, 16'h0015);

    // 4: reload while two reads are in flight (ptr=1)
    lif4.addr[20 +: 20] = 20'd0;
    lif4.addr[40 +: 20] = 20'd7;
    lif4.req = 4'b0110;
    tick();
    chk("t4 gnt lane1", lif4.gnt, 4'b0010);
    lif4.req = 4'b0100;
    tick();
    chk("t4 gnt lane2", lif4.gnt, 4'b0100);
    for (int i = 0; i < 4; i++) fifo.push_back(16'h00A0 + 16'(i));
    lif4.addr[60 +: 20] = 20'd3;
    lif4.req   = 4'b1000;
    load_start = 1'b1;
    ref_len    = 32'd4;
    tick();
    load_start = 1'b0;
    lif4.req   = '0;
    chk("t4 no gnt on load", lif4.gnt, 0);
    chk("t4 ready drop", ready, 0);
    chk("t4 state drain", state, 4);
    chk("t4 rvalid lane1", lif4.rvalid, 4'b0010);
    chk("t4 rdata lane1", lif4.rdata, 16'h0010);
    tick();
    chk("t4 drain gnt", lif4.gnt, 0);
    chk("t4 rvalid lane2", lif4.rvalid, 4'b0100);
    chk("t4 rdata lane2", lif4.rdata, 16'h0017);
    tick();
    chk("t4 no extra rvalid", lif4.rvalid, 0);
    chk("t4 state load", state, 1);
    chk("t4 mode load", core_mode, 1);
    // load_start inside LOAD must be ignored
    load_start = 1'b1;
    ref_len    = 32'd99;
    tick();
    load_start = 1'b0;
    chk("t4 ignore len", core_len, 4);
    wait_ready(60, "t4 reload ready", saw);
    chk("t4 len kept", core_len, 4);
    read1(2, 20'd2, 16'h00A2, "t4 new lane2");
    read1(1, 20'd3, 16'h00A3, "t4 new lane1");

    // Empty reference: ready comes back without a load-done pulse
    load_start = 1'b1;
    ref_len    = 32'd0;
    tick();
    load_start = 1'b0;
    chk("len0 ready drop", ready, 0);
    wait_ready(60, "len0 ready", saw);
    chk("len0 len", core_len, 0);

    // 5: asynchronous reset with a read in flight
    lif4.addr[0 +: 20] = 20'd1;
    lif4.req = 4'b0001;
    tick();
    chk("t5 gnt", lif4.gnt, 4'b0001);
    lif4.req = '0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5 rst gnt", lif4.gnt, 0);
    chk("t5 rst ready", ready, 0);
    chk("t5 rst state", state, 0);
    chk("t5 rst addr", core_addr, 0);
    chk("t5 rst rs", core_rs, 0);
    chk("t5 rst len", core_len, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t5 no rvalid %0d", k), lif4.rvalid, 0);
    end

    // 6: 3-lane build, continuous requests -> 0,1,2,0
    load_start3 = 1'b1;
    ref_len3    = 32'd5;
    core3_done  = 1'b1;
    tick();
    load_start3 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (state3 == 3'd2) break;
      tick();
    end
    chk("t6 enter", state3, 2);
    core3_done = 1'b0;
    core3_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ready3) break;
      tick();
    end
    chk("t6 ready", ready3, 1);
    lif3.addr = {20'h0000C, 20'h0000B, 20'h0000A};
    exp_g3 = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_d3 = '{16'h010A, 16'h010B, 16'h010C, 16'h010A};
    lif3.req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k < 4) chk($sformatf("t6 gnt %0d", k), lif3.gnt, exp_g3[k]);
      else chk($sformatf("t6 gnt idle %0d", k), lif3.gnt, 0);
      if (k >= 2) begin
        chk($sformatf("t6 rvalid %0d", k), lif3.rvalid, exp_g3[k-2]);
        chk($sformatf("t6 rdata %0d", k), lif3.rdata, exp_d3[k-2]);
      end
      if (k == 3) lif3.req = '0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
